// File: rtl/trap_pkg.sv
// Shared trap-controller types: FSM states, cause codes and mstatus field positions.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    RET   = 2'd2,
    REDIR = 2'd3
  } state_e;

  localparam logic [3:0] EXC_FETCH_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL        = 4'd2;
  localparam logic [3:0] EXC_EBREAK         = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL          = 4'd11;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [11:0] IRQ_MASK = 12'h888;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

endpackage

// File: rtl/irq_prio.sv
// Machine interrupt priority encoder: external > software > timer.
module irq_prio
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mip_i,
  output logic            irq_pend_o,
  output logic [3:0]      irq_code_o
);

  logic [11:0] pend;
  logic        unused_hi;

  assign pend      = mie_i[11:0] & mip_i[11:0] & IRQ_MASK;
  assign unused_hi = ^{mie_i[XLEN-1:12], mip_i[XLEN-1:12]};

  always_comb begin
    irq_code_o = '0;
    if (pend[IRQ_MEI])      irq_code_o = IRQ_MEI;
    else if (pend[IRQ_MSI]) irq_code_o = IRQ_MSI;
    else if (pend[IRQ_MTI]) irq_code_o = IRQ_MTI;
  end

  assign irq_pend_o = mstatus_mie_i & (|pend);

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return sequencer: latches trap CSRs, updates mstatus, redirects fetch.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            mret,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mbadaddr,
  output logic [XLEN-1:0] mepc,
  output logic            mstatus_we,
  output logic [XLEN-1:0] mstatus_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mbadaddr_q, mbadaddr_d;
  logic            irq_q, irq_d;
  logic            ret_q, ret_d;

  logic            irq_pend;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] epc_src;
  logic [XLEN-1:0] tvec_tgt;

  irq_prio #(.XLEN(XLEN)) u_irq_prio (
    .mstatus_mie_i (mstatus_in[MIE_BIT]),
    .mie_i         (mie),
    .mip_i         (mip),
    .irq_pend_o    (irq_pend),
    .irq_code_o    (irq_code)
  );

  assign epc_src = exc_valid ? exc_pc : irq_pc;

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign tvec_tgt = {mtvec[XLEN-1:2], 2'b00} +
                    ((irq_q && mtvec[1:0] == 2'b01) ?
                     {{(XLEN-6){1'b0}}, mcause_q[3:0], 2'b00} : {XLEN{1'b0}});

  always_comb begin
    state_d        = state_q;
    mcause_d       = mcause_q;
    mepc_d         = mepc_q;
    mbadaddr_d     = mbadaddr_q;
    irq_d          = irq_q;
    ret_d          = ret_q;
    mstatus_we     = 1'b0;
    mstatus_wdata  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (irq_pend || exc_valid) begin
          state_d        = TRAP;
          irq_d          = irq_pend;
          ret_d          = 1'b0;
          mcause_d       = '0;
          mcause_d[XLEN-1] = irq_pend;
          mcause_d[3:0]  = irq_pend ? irq_code : exc_code;
          mepc_d         = {epc_src[XLEN-1:2], 2'b00};
          mbadaddr_d     = irq_pend ? '0 : exc_tval;
        end else if (mret) begin
          state_d = RET;
          ret_d   = 1'b1;
        end
      end
      TRAP: begin
        mstatus_we                    = 1'b1;
        mstatus_wdata                 = mstatus_in;
        mstatus_wdata[MPIE_BIT]       = mstatus_in[MIE_BIT];
        mstatus_wdata[MIE_BIT]        = 1'b0;
        mstatus_wdata[MPP_HI:MPP_LO]  = 2'b11;
        state_d                       = REDIR;
      end
      RET: begin
        mstatus_we              = 1'b1;
        mstatus_wdata           = mstatus_in;
        mstatus_wdata[MIE_BIT]  = mstatus_in[MPIE_BIT];
        mstatus_wdata[MPIE_BIT] = 1'b1;
        state_d                 = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = ret_q ? mepc_q : tvec_tgt;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      mcause_q   <= '0;
      mepc_q     <= '0;
      mbadaddr_q <= '0;
      irq_q      <= 1'b0;
      ret_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcause_q   <= mcause_d;
      mepc_q     <= mepc_d;
      mbadaddr_q <= mbadaddr_d;
      irq_q      <= irq_d;
      ret_q      <= ret_d;
    end
  end

  assign mcause   = mcause_q;
  assign mepc     = mepc_q;
  assign mbadaddr = mbadaddr_q;
  assign busy     = (state_q != IDLE);

endmodule
